// File: rtl/axi_pkg.sv
// Shared AXI3 types and constants for the SRAM responder slice.
package axi_pkg;

  typedef logic [3:0] axi_id_t;
  typedef logic [3:0] axi_len_t;
  typedef logic [2:0] axi_size_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam axi_size_t AXI_SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    WRESP
  } rsp_state_t;

  typedef enum logic {
    PRIO_RD,
    PRIO_WR
  } rsp_prio_t;

endpackage

// File: rtl/axi_resp_ram.sv
// Single-port synchronous word RAM with byte write enables; reads return pre-write data.
module axi_resp_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 slave serving one read or write burst at a time from an on-chip byte-writable RAM.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> 2) >= DEPTH_WORDS);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  rsp_state_t  state;
  rsp_prio_t   prio;
  axi_id_t     id;
  logic [31:0] addr;
  axi_len_t    len;
  axi_len_t    cnt;
  axi_burst_t  burst;
  logic        err;
  logic        primed;
  logic        rd_ok;

  logic          grant_rd, grant_wr, r_hs, w_hs, last_cnt, cur_err;
  logic [31:0]   next_addr;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  always_comb begin
    grant_rd  = arvalid & ((prio == PRIO_RD) | ~awvalid);
    grant_wr  = awvalid & ~grant_rd;
    arready   = ~reset & (state == IDLE) & grant_rd;
    awready   = ~reset & (state == IDLE) & grant_wr;
    next_addr = (burst == FIXED) ? addr : addr + 32'd4;
    cur_err   = err | addr_bad(addr);
    r_hs      = rvalid & rready;
    w_hs      = wvalid & wready;
    last_cnt  = (cnt == len);
    // Steering to the next beat on a read handshake keeps back-to-back beats at one per cycle.
    ram_addr  = (state == READ && r_hs) ? word_idx(next_addr) : word_idx(addr);
    ram_we    = (state == WRITE && w_hs && !cur_err) ? wstrb : '0;
    rdata     = rd_ok ? ram_rdata : '0;
  end

  axi_resp_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      prio   <= PRIO_RD;
      id     <= '0;
      addr   <= '0;
      len    <= '0;
      cnt    <= '0;
      burst  <= FIXED;
      err    <= 1'b0;
      primed <= 1'b0;
      rd_ok  <= 1'b0;
      rvalid <= 1'b0;
      rid    <= '0;
      rresp  <= OKAY;
      rlast  <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bid    <= '0;
      bresp  <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd) begin
            id     <= arid;
            addr   <= araddr;
            len    <= arlen;
            burst  <= axi_burst_t'(arburst);
            err    <= (arsize != AXI_SIZE_WORD) | arburst[1];
            cnt    <= '0;
            primed <= 1'b0;
            prio   <= PRIO_WR;
            state  <= READ;
          end else if (grant_wr) begin
            id     <= awid;
            addr   <= awaddr;
            len    <= awlen;
            burst  <= axi_burst_t'(awburst);
            err    <= (awsize != AXI_SIZE_WORD) | awburst[1];
            cnt    <= '0;
            prio   <= PRIO_RD;
            wready <= 1'b1;
            state  <= WRITE;
          end
        end

        READ: begin
          if (!rvalid) begin
            // One idle cycle after accept, then the first RAM read lands with rvalid.
            if (!primed) begin
              primed <= 1'b1;
            end else begin
              rvalid <= 1'b1;
              rid    <= id;
              rresp  <= cur_err ? SLVERR : OKAY;
              rd_ok  <= ~cur_err;
              rlast  <= last_cnt;
            end
          end else if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              rd_ok  <= 1'b0;
              state  <= IDLE;
            end else begin
              addr  <= next_addr;
              cnt   <= cnt + 4'd1;
              err   <= cur_err;
              rresp <= (cur_err | addr_bad(next_addr)) ? SLVERR : OKAY;
              rd_ok <= ~(cur_err | addr_bad(next_addr));
              rlast <= (cnt + 4'd1 == len);
            end
          end
        end

        WRITE: begin
          if (w_hs) begin
            addr <= next_addr;
            cnt  <= cnt + 4'd1;
            if (wlast | last_cnt) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id;
              bresp  <= (cur_err | (wlast != last_cnt)) ? SLVERR : OKAY;
              state  <= WRESP;
            end else begin
              err <= cur_err;
            end
          end
        end

        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized bench for axi_sram_responder against a word-array reference model.
module tb_axi_sram_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_sram_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk     (clk),     .reset   (reset),
    .arid    (arid),    .araddr  (araddr),  .arlen   (arlen),   .arsize  (arsize),
    .arburst (arburst), .arvalid (arvalid), .arready (arready),
    .rid     (rid),     .rdata   (rdata),   .rresp   (rresp),   .rlast   (rlast),
    .rvalid  (rvalid),  .rready  (rready),
    .awid    (awid),    .awaddr  (awaddr),  .awlen   (awlen),   .awsize  (awsize),
    .awburst (awburst), .awvalid (awvalid), .awready (awready),
    .wdata   (wdata),   .wstrb   (wstrb),   .wlast   (wlast),   .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),     .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready)
  );

  always #5 clk = ~clk;

  int unsigned nchk = 0;
  int unsigned nerr = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  task automatic addr_hs(input bit wr, input logic [3:0] id, input logic [31:0] a,
                         input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    if (wr) begin
      awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    end else begin
      arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    end
    for (int k = 0; k < 64 && !ok; k++) begin
      #1 ok = wr ? awready : arready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    arvalid = 1'b0;
    check(wr ? "aw_hs" : "ar_hs", 64'(ok), 64'd1);
  endtask

  // mode 0: rready always high, 1: random, 2: pattern 1,0,0,1,0,0...
  task automatic read_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
    bit e, held, first;
    int b;
    logic [31:0] ea, exp_d, hd;
    logic [2:0]  hc;
    addr_hs(1'b0, id, a, len, size, burst);
    e = (size != 3'b010) || burst[1];
    b = 0; held = 0; first = 1; hd = '0; hc = '0;
    for (int t = 0; t < 200 && b <= int'(len); t++) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'(t % 3 == 0);
      #1;
      if (rvalid) begin
        if (first) begin
          check("r_latency", 64'(t), 64'd2);
          first = 0;
        end
        if (held) check("r_hold", {rdata, rresp, rlast}, {hd, hc});
        if (rready) begin
          ea    = beat_addr(a, burst, b);
          e     = e | bad(ea);
          exp_d = e ? '0 : mdl[widx(ea)];
          check("r_data", 64'(rdata), 64'(exp_d));
          check("r_ctl", {rid, rresp, rlast}, {id, (e ? 2'b10 : 2'b00), 1'(b == int'(len))});
          if (mode == 0) check("r_b2b", 64'(t), 64'(2 + b));
          b++;
          held = 0;
        end else begin
          held = 1; hd = rdata; hc = {rresp, rlast};
        end
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check("r_done", 64'(b), 64'(int'(len) + 1));
    check("r_drop", 64'(rvalid), 64'd0);
  endtask

  // Sends beats 0..min(wl_at,len); wl_at marks the beat carrying wlast (beyond len: never).
  task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int wl_at,
                             input int bhold, input bit early);
    int last;
    bit e, ok;
    logic [31:0] ea;
    last = (wl_at < int'(len)) ? wl_at : int'(len);
    e = (size != 3'b010) || burst[1];
    for (int i = 0; i <= last; i++) begin
      ea = beat_addr(a, burst, i);
      e  = e | bad(ea);
      if (!e)
        for (int j = 0; j < 4; j++)
          if (ws[i][j]) mdl[widx(ea)][8*j +: 8] = wd[i][8*j +: 8];
    end
    e = e | ((wl_at == last) != (last == int'(len)));
    if (early) begin
      wdata = wd[0]; wstrb = ws[0]; wlast = 1'(wl_at == 0); wvalid = 1'b1;
      #1 check("w_wait", 64'(wready), 64'd0);
    end
    addr_hs(1'b1, id, a, len, size, burst);
    for (int i = 0; i <= last; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = 1'(wl_at == i); wvalid = 1'b1;
      ok = 0;
      for (int k = 0; k < 32 && !ok; k++) begin
        #1 ok = wready;
        @(posedge clk); #1;
      end
      check("w_hs", 64'(ok), 64'd1);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    for (int k = 0; k < bhold; k++) begin
      #1 check("b_hold", {bvalid, bresp, bid}, {1'b1, (e ? 2'b10 : 2'b00), id});
      @(posedge clk); #1;
    end
    bready = 1'b1;
    ok = 0;
    for (int k = 0; k < 32 && !ok; k++) begin
      #1;
      if (bvalid) begin
        ok = 1;
        check("b_resp", {bresp, bid}, {(e ? 2'b10 : 2'b00), id});
      end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    check("b_hs", 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  bst;
    logic [2:0]  sz;
    logic [3:0]  ln;
    int          ng;
    logic        order [3];

    reset = 1'b1;
    {arid, araddr, arlen, arsize, arburst} = '0;
    {awid, awaddr, awlen, awsize, awburst} = '0;
    {wdata, wstrb, wlast, wvalid, rready, bready} = '0;
    arvalid = 1'b1;
    awvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {arready, awready, wready}, 64'd0);
    check("rst_valid", {rvalid, bvalid}, 64'd0);
    check("rst_r", {rid, rdata, rresp, rlast}, 64'd0);
    check("rst_b", {bid, bresp}, 64'd0);
    arvalid = 1'b0;
    awvalid = 1'b0;
    reset   = 1'b0;
    @(posedge clk); #1;

    for (int blk = 0; blk < int'(DEPTH / 16); blk++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
      end
      write_burst(4'(blk), BASE + 32'(64 * blk), 4'd15, 3'b010, 2'b01, 15, 0, 1'b0);
    end

    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    write_burst(4'h1, BASE + 32'h40, 4'd0, 3'b010, 2'b01, 0, 0, 1'b0);
    read_burst(4'h1, BASE + 32'h40, 4'd0, 3'b010, 2'b01, 0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1);
      ws[i] = 4'hF;
    end
    write_burst(4'h2, BASE + 32'h100, 4'd3, 3'b010, 2'b01, 3, 0, 1'b0);
    read_burst(4'h5, BASE + 32'h100, 4'd3, 3'b010, 2'b01, 0);

    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    write_burst(4'h3, BASE + 32'h200, 4'd0, 3'b010, 2'b01, 0, 0, 1'b0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'h1;
    wd[1] = 32'hAABB_CCDD; ws[1] = 4'h8;
    write_burst(4'h3, BASE + 32'h200, 4'd1, 3'b010, 2'b00, 1, 0, 1'b1);
    read_burst(4'h3, BASE + 32'h200, 4'd0, 3'b010, 2'b01, 0);

    read_burst(4'h6, BASE + 32'h100, 4'd2, 3'b010, 2'b01, 2);
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
    write_burst(4'h7, BASE + 32'h300, 4'd0, 3'b010, 2'b01, 0, 5, 1'b0);

    read_burst(4'h8, BASE + 32'h40, 4'd0, 3'b000, 2'b01, 0);
    wd[0] = 32'h5555_5555; ws[0] = 4'hF;
    write_burst(4'h9, BASE + 32'(4 * DEPTH), 4'd0, 3'b010, 2'b01, 0, 0, 1'b0);
    read_burst(4'h9, BASE, 4'd0, 3'b010, 2'b01, 0);
    read_burst(4'hB, BASE - 32'd4, 4'd1, 3'b010, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    write_burst(4'hA, BASE + 32'h180, 4'd3, 3'b010, 2'b01, 1, 0, 1'b0);
    read_burst(4'hA, BASE + 32'h180, 4'd3, 3'b010, 2'b01, 0);

    for (int n = 0; n < 60; n++) begin
      a   = BASE - 32'd16 + 32'($urandom_range(0, 4 * DEPTH + 32));
      ln  = 4'($urandom_range(0, 15));
      d   = 32'($urandom_range(0, 9));
      bst = (d < 3) ? 2'b00 : (d < 9) ? 2'b01 : 2'($urandom_range(2, 3));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = $urandom;
          ws[i] = 4'($urandom);
        end
        write_burst(4'($urandom), a, ln, sz, bst,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) : int'(ln),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      end else begin
        read_burst(4'($urandom), a, ln, sz, bst, int'($urandom_range(0, 2)));
      end
    end

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    d = $urandom;
    arid = 4'h1; araddr = BASE + 32'h40; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01;
    awid = 4'h2; awaddr = BASE + 32'h80; awlen = 4'd0; awsize = 3'b010; awburst = 2'b01;
    wdata = d; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arvalid = 1'b1; awvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    ng = 0;
    order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b1;
    for (int k = 0; k < 60 && ng < 3; k++) begin
      #1;
      if (arready) begin
        order[ng] = 1'b0;
        ng++;
      end else if (awready) begin
        order[ng] = 1'b1;
        ng++;
      end
      @(posedge clk); #1;
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rready = 1'b0; bready = 1'b0;
    mdl[widx(BASE + 32'h80)] = d;
    check("arb_count", 64'(ng), 64'd3);
    check("arb_first_read", 64'(order[0]), 64'd0);
    check("arb_then_write", 64'(order[1]), 64'd1);
    check("arb_then_read", 64'(order[2]), 64'd0);
    read_burst(4'h2, BASE + 32'h80, 4'd0, 3'b010, 2'b01, 0);

    addr_hs(1'b0, 4'h3, BASE + 32'h100, 4'd7, 3'b010, 2'b01);
    rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rvalid", 64'(rvalid), 64'd1);
    arvalid = 1'b1;
    araddr  = BASE;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {rvalid, arready, rlast}, 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    arvalid = 1'b0;
    rready  = 1'b0;
    reset   = 1'b0;
    @(posedge clk); #1;
    read_burst(4'h4, BASE + 32'h100, 4'd3, 3'b010, 2'b01, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI3 slave that terminates the CPU-side AXI master's bus on a word-addressed, byte-writable on-chip memory.
- Serves one transaction at a time: read or write bursts, FIXED/INCR, up to 16 beats.
- Used as the simulation/test memory behind the CBus-to-AXI path and as a boot RAM in standalone benches.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the backing memory.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- arid  in  4  read ID
- araddr  in  32  read start byte address
- arlen  in  4  beats-1
- arsize  in  3  beat size; only 3'b010 legal
- arburst  in  2  burst type
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  4  echoed arid
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- awid, awaddr, awlen, awsize, awburst  in  4/32/4/3/2  write address channel, same meaning as AR
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  last write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  4  echoed awid
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- Lock, cache and prot inputs are not ported; wid is ignored by design.

Behaviour:
- Reset (async, any state, mid-burst included):
  - All ready/valid outputs 0; rid, rdata, rresp, rlast, bid, bresp = 0.
  - FSM goes to IDLE; priority pointer set to READ.
  - Memory contents are not cleared.
- FSM states: IDLE, READ, WRITE, WRESP.
- IDLE arbitration:
  - grant_rd = arvalid & (prio==READ | !awvalid); grant_wr = awvalid & !grant_rd.
  - arready = IDLE & grant_rd; awready = IDLE & grant_wr.
  - On a handshake: latch id, addr, len, burst, err; clear beat counter; toggle prio. AR handshake goes to READ, AW handshake goes to WRITE.
- err flag is set at accept when any of these hold:
  - size != 3'b010;
  - burst is WRAP (2'b10) or reserved (2'b11);
  - start address < BASE_ADDR;
  - word index (addr-BASE_ADDR)>>2 of any beat >= DEPTH_WORDS. For INCR this is checked per beat as the address advances.
- Address rule:
  - INCR: addr += 4 per beat, 32-bit wrap-around.
  - FIXED: address is held.
  - Address bits [1:0] are ignored.
- READ:
  - Memory read is synchronous, 1 cycle.
  - AR handshake at edge N gives rvalid=1 after edge N+2.
  - rdata/rresp/rlast are held stable while rvalid & !rready.
  - With rready held 1, beats stream back-to-back, one per cycle: the RAM address is muxed to the next address on the handshake.
  - rlast=1 on beat index == len.
  - Errored beat: rdata=0, rresp=2'b10 (SLVERR); otherwise OKAY.
  - Handshake on the last beat: rvalid drops next cycle, FSM returns to IDLE.
- WRITE:
  - wready=1 throughout.
  - On each W handshake, bytes with wstrb set are written at the current address, unless the beat is errored.
  - Burst ends on the first beat where wlast=1 or counter==len; FSM then goes to WRESP.
  - wlast != (counter==len) on any beat sets sticky err.
  - W beats presented before the AW handshake wait, since wready=0 outside WRITE.
- WRESP:
  - bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00.
  - On bready handshake, go to IDLE; the next grant is possible the following cycle.
- Simultaneous arvalid & awvalid in IDLE: the grant alternates; the first grant after reset goes to read.
- len=0 is a single beat with rlast/completion on that beat.

Decomposition:
- Shared package axi_pkg:
  - axi_id_t (4b), axi_len_t (4b), axi_size_t (3b), axi_burst_t enum (FIXED/INCR/WRAP), axi_resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - constant AXI_SIZE_WORD=3'b010.
- Sub-module axi_resp_ram: single-port synchronous RAM, DEPTH_WORDS x 32, 4-bit byte write enable, 1-cycle read latency, read-during-write returns old data.

Test Plan:
- Single write then read: AW addr 0x40, len 0, wdata 0xDEADBEEF, wstrb 4'hF; then AR 0x40 -> bresp OKAY; rdata 0xDEADBEEF, rlast=1, rvalid 2 cycles after AR handshake.
- INCR burst: write len 3 at 0x100 with data 1,2,3,4; read back with rready held 1 -> four consecutive-cycle beats 1,2,3,4, rlast only on the 4th, rid echoes arid=4'h5.
- Byte strobes and FIXED: word at 0x200 = 0x11223344; FIXED write len 1, wstrb 4'h1 then 4'h8, data 0xAABBCCDD both beats -> readback 0xAA2233DD.
- Backpressure: read len 2 with rready toggling 1,0,0,1,... -> no beat lost or duplicated, rdata stable while stalled; bready held 0 for 5 cycles -> bvalid and bresp held.
- Errors:
  - arsize 3'b000 -> rresp SLVERR, rdata 0.
  - Write to BASE_ADDR+4*DEPTH_WORDS -> bresp SLVERR, memory unchanged.
  - Early wlast on beat 1 of a len-3 burst -> bresp SLVERR, FSM back to IDLE.
- Arbitration and reset: arvalid and awvalid both high every cycle -> grants alternate R,W,R; async reset asserted mid read burst -> rvalid/arready deassert immediately, and a fresh read after release returns the previously written data.
